// File: rtl/p_hardisc.sv
// CLINT shared definitions: register byte offsets and error-response states.
// CLINT_PRESCALER_EN maps the mtime prescaler register at CLINT_PRESC.
package p_hardisc;

    localparam logic [4:0] CLINT_MSIP       = 5'h00;
    localparam logic [4:0] CLINT_MTIMECMP_L = 5'h08;
    localparam logic [4:0] CLINT_MTIMECMP_H = 5'h0C;
    localparam logic [4:0] CLINT_MTIME_L    = 5'h10;
    localparam logic [4:0] CLINT_MTIME_H    = 5'h14;
    localparam logic [4:0] CLINT_PRESC      = 5'h18;

    typedef enum logic [1:0] {
        CLINT_IDLE,
        CLINT_ERR1,
        CLINT_ERR2
    } clint_st_t;

    function automatic logic clint_mapped(input logic [4:0] boff);
        logic hit;
        hit = (boff == CLINT_MSIP)
            || (boff == CLINT_MTIMECMP_L)
            || (boff == CLINT_MTIMECMP_H)
            || (boff == CLINT_MTIME_L)
            || (boff == CLINT_MTIME_H);
`ifdef CLINT_PRESCALER_EN
        hit = hit || (boff == CLINT_PRESC);
`endif
        return hit;
    endfunction

endpackage

// File: rtl/clint_mtime.sv
// 64-bit mtime counter with write override and optional tick prescaler.
// CLINT_PRESCALER_EN enables the PRESC_W-bit prescaler; otherwise it ticks every cycle.
module clint_mtime #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               wr_lo,
    input  logic               wr_hi,
    input  logic               wr_presc,
    input  logic [31:0]        wdata,
    output logic [63:0]        mtime,
    output logic [PRESC_W-1:0] presc
);

    logic tick;

`ifdef CLINT_PRESCALER_EN
    logic [PRESC_W-1:0] cnt;

    assign tick = (cnt == presc);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            presc <= '0;
            cnt   <= '0;
        end else if (wr_presc) begin
            presc <= wdata[PRESC_W-1:0];
            cnt   <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + PRESC_W'(1);
        end
    end
`else
    logic unused_presc;

    assign tick         = 1'b1;
    assign presc        = '0;
    assign unused_presc = wr_presc;
`endif

    // A bus write to either half wins over the tick for the whole counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mtime <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) mtime[31:0]  <= wdata;
            if (wr_hi) mtime[63:32] <= wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: rtl/ahb_clint.sv
// AHB-Lite CLINT: msip, mtimecmp and mtime registers with mtip/msip outputs.
// CLINT_PRESCALER_EN adds the mtime prescaler register at offset 0x18.
module ahb_clint
    import p_hardisc::*;
#(
    parameter int          PRESC_W      = 8,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_hsel_i,
    input  logic [1:0]  s_htrans_i,
    input  logic        s_hwrite_i,
    input  logic [2:0]  s_hsize_i,
    input  logic [31:0] s_haddr_i,
    input  logic [31:0] s_hwdata_i,
    input  logic        s_hready_i,
    output logic [31:0] s_hrdata_o,
    output logic        s_hreadyout_o,
    output logic        s_hresp_o,
    output logic        s_int_mtip_o,
    output logic        s_int_msip_o
);

    clint_st_t          state;
    clint_st_t          state_nxt;
    logic               acc;
    logic               bad;
    logic               dvalid;
    logic               dwrite;
    logic [4:0]         doff;
    logic               wr;
    logic               wr_lo;
    logic               wr_hi;
    logic               wr_presc;
    logic               msip;
    logic               mtip;
    logic [63:0]        mtimecmp;
    logic [63:0]        mtime;
    logic [PRESC_W-1:0] presc;
    logic [31:0]        rdata;
    logic               unused_bits;

    // Address phases are ignored while the first ERROR cycle is on the bus.
    assign acc = s_hsel_i & s_htrans_i[1] & s_hready_i
               & (state != CLINT_ERR1);
    assign bad = (s_hsize_i != 3'b010)
               | (s_haddr_i[1:0] != 2'b00)
               | ~clint_mapped({s_haddr_i[4:2], 2'b00});

    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) state <= CLINT_IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = CLINT_IDLE;
        case (state)
            CLINT_ERR1: state_nxt = CLINT_ERR2;
            default:    if (acc && bad) state_nxt = CLINT_ERR1;
        endcase
    end

    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) begin
            dvalid <= 1'b0;
            dwrite <= 1'b0;
            doff   <= '0;
        end else begin
            dvalid <= acc & ~bad;
            if (acc) begin
                dwrite <= s_hwrite_i;
                doff   <= {s_haddr_i[4:2], 2'b00};
            end
        end
    end

    assign wr    = dvalid & dwrite;
    assign wr_lo = wr & (doff == CLINT_MTIME_L);
    assign wr_hi = wr & (doff == CLINT_MTIME_H);
`ifdef CLINT_PRESCALER_EN
    assign wr_presc = wr & (doff == CLINT_PRESC);
`else
    assign wr_presc = 1'b0;
`endif

    clint_mtime #(
        .PRESC_W (PRESC_W)
    ) u_mtime (
        .clk      (s_clk_i),
        .resetn   (s_resetn_i),
        .wr_lo    (wr_lo),
        .wr_hi    (wr_hi),
        .wr_presc (wr_presc),
        .wdata    (s_hwdata_i),
        .mtime    (mtime),
        .presc    (presc)
    );

    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) begin
            msip     <= 1'b0;
            mtimecmp <= MTIMECMP_RST;
            mtip     <= 1'b0;
        end else begin
            if (wr && doff == CLINT_MSIP)
                msip <= s_hwdata_i[0];
            if (wr && doff == CLINT_MTIMECMP_L)
                mtimecmp[31:0] <= s_hwdata_i;
            if (wr && doff == CLINT_MTIMECMP_H)
                mtimecmp[63:32] <= s_hwdata_i;
            mtip <= (mtime >= mtimecmp);
        end
    end

    always_comb begin
        rdata = '0;
        if (dvalid) begin
            case (doff)
                CLINT_MSIP:       rdata = {31'd0, msip};
                CLINT_MTIMECMP_L: rdata = mtimecmp[31:0];
                CLINT_MTIMECMP_H: rdata = mtimecmp[63:32];
                CLINT_MTIME_L:    rdata = mtime[31:0];
                CLINT_MTIME_H:    rdata = mtime[63:32];
`ifdef CLINT_PRESCALER_EN
                CLINT_PRESC:      rdata = 32'(presc);
`endif
                default:          rdata = '0;
            endcase
        end
    end

`ifdef CLINT_PRESCALER_EN
    assign unused_bits = ^{s_haddr_i[31:5], s_htrans_i[0]};
`else
    assign unused_bits = ^{s_haddr_i[31:5], s_htrans_i[0], presc};
`endif

    assign s_hrdata_o    = rdata;
    assign s_hreadyout_o = (state != CLINT_ERR1);
    assign s_hresp_o     = (state != CLINT_IDLE);
    assign s_int_mtip_o  = mtip;
    assign s_int_msip_o  = msip;

endmodule

// File: tb/tb_ahb_clint.sv
// Self-checking bench for ahb_clint: directed scenarios plus random bus traffic
// against a cycle-level behavioural model of the CLINT registers.
module tb_ahb_clint;

`ifdef CLINT_PRESCALER_EN
    localparam bit PRESC_EN = 1'b1;
`else
    localparam bit PRESC_EN = 1'b0;
`endif
    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic        mtip_o;
    logic        msip_o;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] m_time;
    logic [63:0] m_cmp;
    logic        m_msip;
    logic        m_mtip;
    logic [7:0]  m_presc;
    int          m_since;

    always #5 clk = ~clk;

    ahb_clint dut (
        .s_clk_i       (clk),
        .s_resetn_i    (resetn),
        .s_hsel_i      (hsel),
        .s_htrans_i    (htrans),
        .s_hwrite_i    (hwrite),
        .s_hsize_i     (hsize),
        .s_haddr_i     (haddr),
        .s_hwdata_i    (hwdata),
        .s_hready_i    (hready),
        .s_hrdata_o    (hrdata),
        .s_hreadyout_o (hreadyout),
        .s_hresp_o     (hresp),
        .s_int_mtip_o  (mtip_o),
        .s_int_msip_o  (msip_o)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [2:0] off);
        case (off)
            3'd0:    return {31'd0, m_msip};
            3'd2:    return m_cmp[31:0];
            3'd3:    return m_cmp[63:32];
            3'd4:    return m_time[31:0];
            3'd5:    return m_time[63:32];
            3'd6:    return PRESC_EN ? 32'(m_presc) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge; wr/off/wd describe the data phase ending at this edge.
    task automatic step(input bit wr, input logic [2:0] off,
                        input logic [31:0] wd);
        bit tk;
        bit nm;
        @(posedge clk);
        if (!resetn) begin
            m_time  = '0;
            m_cmp   = '1;
            m_msip  = 1'b0;
            m_mtip  = 1'b0;
            m_presc = '0;
            m_since = 0;
        end else begin
            nm = (m_time >= m_cmp);
            tk = !PRESC_EN
              || ((m_since % (int'(m_presc) + 1)) == int'(m_presc));
            m_since++;
            if (wr && off == 3'd4)      m_time[31:0]  = wd;
            else if (wr && off == 3'd5) m_time[63:32] = wd;
            else if (tk)                m_time        = m_time + 64'd1;
            if (wr && off == 3'd2) m_cmp[31:0]  = wd;
            if (wr && off == 3'd3) m_cmp[63:32] = wd;
            if (wr && off == 3'd0) m_msip       = wd[0];
            if (wr && off == 3'd6 && PRESC_EN) begin
                m_presc = wd[7:0];
                m_since = 0;
            end
            m_mtip = nm;
        end
        #1;
        chk("mtip", mtip_o, m_mtip);
        chk("msip", msip_o, m_msip);
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'b000;
        haddr  = $urandom;
        hready = 1'b1;
    endtask

    task automatic xfer(input bit wr, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output bit err);
        logic [2:0] off;
        bit         bad;
        off = addr[4:2];
        bad = (size != 3'b010) || (addr[1:0] != 2'b00)
           || off == 3'd1 || off == 3'd7 || (off == 3'd6 && !PRESC_EN);
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = wr;
        hsize  = size;
        haddr  = addr;
        hready = 1'b1;
        hwdata = $urandom;
        step(1'b0, 3'd0, 32'd0);
        bus_idle();
        hwdata = wd;
        err    = hresp;
        rd     = hrdata;
        if (!bad) begin
            chk("ok_rdy", hreadyout, 1);
            chk("ok_resp", hresp, 0);
            chk("ok_rdata", hrdata, rd_model(off));
            step(wr, off, wd);
        end else begin
            chk("err1_rdy", hreadyout, 0);
            chk("err1_resp", hresp, 1);
            chk("err1_rdata", hrdata, 0);
            // Address phase during ERROR cycle 1 must be dropped.
            hsel   = 1'b1;
            htrans = 2'b10;
            hwrite = 1'b1;
            hsize  = 3'b010;
            haddr  = BASE;
            step(1'b0, 3'd0, 32'd0);
            bus_idle();
            hwdata = {31'd0, ~m_msip};
            chk("err2_rdy", hreadyout, 1);
            chk("err2_resp", hresp, 1);
            chk("err2_rdata", hrdata, 0);
            step(1'b0, 3'd0, 32'd0);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                // Address phase qualified off by hready=0.
                hsel   = 1'b1;
                htrans = 2'b10;
                hwrite = 1'b1;
                hsize  = 3'b010;
                haddr  = BASE;
                hready = 1'b0;
                step(1'b0, 3'd0, 32'd0);
                bus_idle();
                hwdata = {31'd0, ~m_msip};
            end
            step(1'b0, 3'd0, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        bit          err;
        logic [2:0]  off;
        logic [2:0]  size;
        logic [1:0]  lo2;
        logic [31:0] wd;
        bit          wr;

        bus_idle();
        hwdata = '0;
        resetn = 1'b0;
        repeat (3) step(1'b0, 3'd0, 32'd0);
        chk("rst_rdy", hreadyout, 1);
        chk("rst_resp", hresp, 0);
        chk("rst_rdata", hrdata, 0);
        chk("rst_mtip", mtip_o, 0);
        chk("rst_msip", msip_o, 0);
        resetn = 1'b1;

        xfer(1'b0, 3'b010, BASE + 32'h08, 32'd0, rd, err);
        chk("cmp_lo_rst", rd, 32'hFFFF_FFFF);
        xfer(1'b0, 3'b010, BASE + 32'h0C, 32'd0, rd, err);
        chk("cmp_hi_rst", rd, 32'hFFFF_FFFF);

        xfer(1'b1, 3'b010, BASE + 32'h0C, 32'd0, rd, err);
        xfer(1'b1, 3'b010, BASE + 32'h08, 32'h10, rd, err);
        xfer(1'b1, 3'b010, BASE + 32'h10, 32'd0, rd, err);
        repeat (16) step(1'b0, 3'd0, 32'd0);
        chk("mtip_pre", mtip_o, 0);
        step(1'b0, 3'd0, 32'd0);
        chk("mtip_rise", mtip_o, 1);

        xfer(1'b1, 3'b010, BASE + 32'h14, 32'd0, rd, err);
        xfer(1'b1, 3'b010, BASE + 32'h10, 32'hFFFF_FFFF, rd, err);
        xfer(1'b0, 3'b010, BASE + 32'h14, 32'd0, rd, err);
        chk("carry_hi", rd, 32'd1);
        xfer(1'b0, 3'b010, BASE + 32'h10, 32'd0, rd, err);
        chk("carry_lo", rd, 32'd2);

        xfer(1'b1, 3'b000, BASE, 32'd1, rd, err);
        chk("byte_err", err, 1);
        chk("byte_msip", msip_o, 0);

        xfer(1'b1, 3'b010, BASE, 32'd1, rd, err);
        chk("msip_set", msip_o, 1);
        xfer(1'b1, 3'b010, BASE, 32'd0, rd, err);
        chk("msip_clr", msip_o, 0);

        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = 1'b0;
        hsize  = 3'b010;
        haddr  = BASE + 32'h04;
        step(1'b0, 3'd0, 32'd0);
        bus_idle();
        chk("abort_err1", hreadyout, 0);
        resetn = 1'b0;
        step(1'b0, 3'd0, 32'd0);
        chk("abort_rdy", hreadyout, 1);
        chk("abort_resp", hresp, 0);
        resetn = 1'b1;
        step(1'b0, 3'd0, 32'd0);
        chk("abort_idle", hresp, 0);

`ifdef CLINT_PRESCALER_EN
        xfer(1'b1, 3'b010, BASE + 32'h18, 32'd3, rd, err);
        xfer(1'b0, 3'b010, BASE + 32'h18, 32'd0, rd, err);
        chk("presc_rd", rd, 32'd3);
        xfer(1'b0, 3'b010, BASE + 32'h10, 32'd0, a, err);
        repeat (10) step(1'b0, 3'd0, 32'd0);
        xfer(1'b0, 3'b010, BASE + 32'h10, 32'd0, rd, err);
        chk("presc_rate", rd - a, 32'd3);
`else
        xfer(1'b0, 3'b010, BASE + 32'h18, 32'd0, rd, err);
        chk("presc_unmapped", err, 1);
`endif

        for (int n = 0; n < 300; n++) begin
            off  = 3'($urandom_range(0, 7));
            wr   = 1'($urandom_range(0, 1));
            size = ($urandom_range(0, 9) == 0)
                 ? 3'($urandom_range(0, 3)) : 3'b010;
            lo2  = ($urandom_range(0, 9) == 0)
                 ? 2'($urandom_range(0, 3)) : 2'b00;
            case (off)
                3'd2: wd = m_time[31:0] + $urandom_range(0, 30);
                3'd3: wd = m_time[63:32] + $urandom_range(0, 1);
                3'd4: wd = ($urandom_range(0, 3) == 0)
                         ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                         : $urandom;
                3'd5: wd = $urandom_range(0, 3);
                3'd6: wd = $urandom_range(0, 3);
                default: wd = $urandom;
            endcase
            xfer(wr, size, BASE | {27'd0, off, lo2}, wd, rd, err);
            idle_cycles($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
